// File: rtl/slc3_input_conditioner_pkg.sv
// slc3_input_pkg: shared constants for the SLC-3 front-panel input conditioner
package slc3_input_pkg;
   localparam int SW_WIDTH_DEFAULT = 10;
   localparam logic KEY_RELEASED = 1'b1;
   localparam int sync_stages = 2;
endpackage

// File: rtl/slc3_input_conditioner_if.sv
// slc3_input_conditioner_if: raw front-panel pins in, conditioned levels/strobes out
interface slc3_input_conditioner_if
   import slc3_input_pkg::*;
#(
   parameter int SW_WIDTH = SW_WIDTH_DEFAULT
);
   logic                Run;
   logic                Continue;
   logic [SW_WIDTH-1:0] SW;
   logic                run_pressed;
   logic                run_pulse;
   logic                continue_pressed;
   logic                continue_pulse;
   logic [SW_WIDTH-1:0] sw_sync;
   modport master (
      output Run, Continue, SW,
      input  run_pressed, run_pulse, continue_pressed, continue_pulse, sw_sync
   );
   modport slave (
      input  Run, Continue, SW,
      output run_pressed, run_pulse, continue_pressed, continue_pulse, sw_sync
   );
endinterface

// File: rtl/slc3_input_conditioner_debounce_channel.sv
// debounce_channel: synchronize an active-low key, debounce it, strobe on accepted press
module debounce_channel
   import slc3_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic Clk,
   input  logic Reset,
   input  logic key_n,
   output logic pressed,
   output logic pulse
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic [sync_stages-1:0] sync;
   logic                   stable;
   logic [CW-1:0]          cnt;
   logic                   key_s;
   assign key_s = sync[sync_stages-1];
   assign pressed = ~stable;
   // synchronizer, then accept a new level only after it holds for DEBOUNCE_CYCLES cycles
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync   <= {sync_stages{KEY_RELEASED}};
         stable <= KEY_RELEASED;
         cnt    <= '0;
         pulse  <= 1'b0;
      end else begin
         sync  <= {sync[sync_stages-2:0], key_n};
         pulse <= 1'b0;
         if (key_s == stable) cnt <= '0;
         else if (cnt == CNT_LAST) begin
            stable <= key_s;
            cnt    <= '0;
            pulse  <= ~key_s;
         end else cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/slc3_input_conditioner.sv
// slc3_input_conditioner: debounced Run/Continue keys and synchronized switch bus
module slc3_input_conditioner
   import slc3_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SW_WIDTH = SW_WIDTH_DEFAULT
) (
   input logic Clk,
   input logic Reset,
   slc3_input_conditioner_if.slave bus
);
   logic [SW_WIDTH-1:0] sw_meta;
   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
      .Clk(Clk), .Reset(Reset), .key_n(bus.Run),
      .pressed(bus.run_pressed), .pulse(bus.run_pulse)
   );
   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_continue (
      .Clk(Clk), .Reset(Reset), .key_n(bus.Continue),
      .pressed(bus.continue_pressed), .pulse(bus.continue_pulse)
   );
   // switches only need metastability protection, not debouncing
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sw_meta     <= '0;
         bus.sw_sync <= '0;
      end else begin
         sw_meta     <= bus.SW;
         bus.sw_sync <= sw_meta;
      end
   end
endmodule

// File: tb/tb_slc3_input_conditioner.sv
// tb_slc3_input_conditioner: window-based reference model plus directed and random key stimulus
module tb_slc3_input_conditioner;
   import slc3_input_pkg::*;
   localparam int MAXE = 4096;
   localparam int DV [2] = '{4, 1};
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run_n = 1'b1;
   logic       cont_n = 1'b1;
   logic [9:0] sw = 10'h3FF;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   slc3_input_conditioner_if #(.SW_WIDTH(10)) b0 ();
   slc3_input_conditioner_if #(.SW_WIDTH(10)) b1 ();
   assign b0.Run = run_n;
   assign b0.Continue = cont_n;
   assign b0.SW = sw;
   assign b1.Run = run_n;
   assign b1.Continue = cont_n;
   assign b1.SW = sw;
   slc3_input_conditioner #(.DEBOUNCE_CYCLES(4), .SW_WIDTH(10)) dut0 (.Clk(clk), .Reset(rst), .bus(b0.slave));
   slc3_input_conditioner #(.DEBOUNCE_CYCLES(1), .SW_WIDTH(10)) dut1 (.Clk(clk), .Reset(rst), .bus(b1.slave));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // history of everything sampled on each rising edge
   logic       rst_h [MAXE];
   logic       key_h [2][MAXE];
   logic [9:0] sw_h  [MAXE];
   logic       st [2][2];
   logic       ep [2][2];
   logic [9:0] esw = '0;
   bit         live = 0;
   int         n = 0;

   // level seen by the debounce logic at edge t: raw key two edges earlier, released near a reset
   function automatic logic synced(int c, int t);
      if (t < 2) return 1'b1;
      if (rst_h[t-1] || rst_h[t-2]) return 1'b1;
      return key_h[c][t-2];
   endfunction

   // model: a change is accepted when the last D synchronized samples all differ from the stable
   // level and no reset fell inside that window
   always @(posedge clk) begin
      if (n >= MAXE) begin
         $display("FAIL edge budget: got %0d expected below %0d", n, MAXE);
         $fatal(1);
      end
      rst_h[n] = rst;
      key_h[0][n] = run_n;
      key_h[1][n] = cont_n;
      sw_h[n] = sw;
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 2; c++) begin
            bit acc;
            acc = !rst && (n >= DV[d]);
            for (int i = 0; i < DV[d] && acc; i++)
               if (rst_h[n-i] || synced(c, n-i) == st[d][c]) acc = 0;
            ep[d][c] = acc && st[d][c];
            st[d][c] = rst ? 1'b1 : (st[d][c] ^ acc);
         end
      end
      esw = (rst || n == 0 || rst_h[n-1]) ? 10'h000 : sw_h[n-1];
      n++;
      live = 1;
   end

   int rp0 = 0, cp0 = 0, rp1 = 0, cp1 = 0;
   // compare every output of both instances against the model on each falling edge
   always @(negedge clk) begin
      if (live) begin
         chk("d4 run_pressed",  b0.run_pressed,      !st[0][0]);
         chk("d4 run_pulse",    b0.run_pulse,        ep[0][0]);
         chk("d4 cont_pressed", b0.continue_pressed, !st[0][1]);
         chk("d4 cont_pulse",   b0.continue_pulse,   ep[0][1]);
         chk("d4 sw_sync",      b0.sw_sync,          esw);
         chk("d1 run_pressed",  b1.run_pressed,      !st[1][0]);
         chk("d1 run_pulse",    b1.run_pulse,        ep[1][0]);
         chk("d1 cont_pressed", b1.continue_pressed, !st[1][1]);
         chk("d1 cont_pulse",   b1.continue_pulse,   ep[1][1]);
         chk("d1 sw_sync",      b1.sw_sync,          esw);
         rp0 += int'(b0.run_pulse);
         cp0 += int'(b0.continue_pulse);
         rp1 += int'(b1.run_pulse);
         cp1 += int'(b1.continue_pulse);
      end
   end

   int snap, snap2, held;
   logic pat [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   initial begin
      for (int d = 0; d < 2; d++) for (int c = 0; c < 2; c++) begin
         st[d][c] = 1'b1;
         ep[d][c] = 1'b0;
      end
      // reset with switches all high
      repeat (3) @(negedge clk);
      chk("reset sw_sync", b0.sw_sync, 10'h000);
      chk("reset run_pressed", b0.run_pressed, 1'b0);
      chk("reset cont_pulse", b0.continue_pulse, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("sw after 1 edge", b0.sw_sync, 10'h000);
      @(negedge clk);
      chk("sw after 2 edges", b0.sw_sync, 10'h3FF);
      repeat (4) @(negedge clk);
      // clean press and release
      run_n = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 2) chk("d1 pulse before k+2", b1.run_pulse, 1'b0);
         if (i == 3) chk("d1 pulse at k+2", b1.run_pulse, 1'b1);
         if (i == 5) chk("d4 pressed before k+5", b0.run_pressed, 1'b0);
         if (i == 6) chk("d4 pulse at k+5", b0.run_pulse, 1'b1);
         if (i == 6) chk("d4 pressed at k+5", b0.run_pressed, 1'b1);
         if (i == 7) chk("d4 pulse at k+6", b0.run_pulse, 1'b0);
      end
      snap = rp0;
      run_n = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 5) chk("release pressed at k+4", b0.run_pressed, 1'b1);
         if (i == 6) chk("release pressed at k+5", b0.run_pressed, 1'b0);
      end
      chk("release pulses", rp0 - snap, 0);
      // glitch of three cycles on Continue
      snap = cp0;
      cont_n = 1'b0;
      repeat (3) @(negedge clk);
      cont_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("glitch pulses", cp0 - snap, 0);
      chk("glitch pressed", b0.continue_pressed, 1'b0);
      // bounce restarts the count
      snap = rp0;
      for (int i = 0; i < 8; i++) begin
         run_n = pat[i];
         @(negedge clk);
      end
      chk("bounce pulse early", rp0 - snap, 0);
      @(negedge clk);
      chk("bounce pulse position", b0.run_pulse, 1'b1);
      repeat (10) @(negedge clk);
      chk("bounce pulses", rp0 - snap, 1);
      run_n = 1'b1;
      repeat (10) @(negedge clk);
      // simultaneous press, then reset mid-count while Run is held
      run_n = 1'b0;
      cont_n = 1'b0;
      repeat (6) @(negedge clk);
      chk("simul run_pulse", b0.run_pulse, 1'b1);
      chk("simul cont_pulse", b0.continue_pulse, 1'b1);
      cont_n = 1'b1;
      repeat (8) @(negedge clk);
      cont_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre-reset run_pressed", b0.run_pressed, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("reset edge run_pressed", b0.run_pressed, 1'b0);
      chk("reset edge cont_pressed", b0.continue_pressed, 1'b0);
      rst = 1'b0;
      snap = rp0;
      snap2 = cp0;
      repeat (5) @(negedge clk);
      chk("post-reset early pulse", rp0 - snap, 0);
      @(negedge clk);
      chk("post-reset run_pulse", b0.run_pulse, 1'b1);
      chk("post-reset cont_pulse", b0.continue_pulse, 1'b1);
      repeat (5) @(negedge clk);
      chk("post-reset run pulses", rp0 - snap, 1);
      chk("post-reset cont pulses", cp0 - snap2, 1);
      run_n = 1'b1;
      cont_n = 1'b1;
      repeat (10) @(negedge clk);
      // long hold
      snap = rp0;
      held = 0;
      run_n = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 94; i++) begin
         @(negedge clk);
         held += int'(b0.run_pressed);
      end
      chk("hold pressed cycles", held, 94);
      chk("hold pulses", rp0 - snap, 1);
      run_n = 1'b1;
      repeat (10) @(negedge clk);
      // random keys, switches and occasional resets
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) run_n = ~run_n;
         if ($urandom_range(0, 5) == 0) cont_n = ~cont_n;
         sw = 10'($urandom);
         rst = ($urandom_range(0, 199) == 0);
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/slc3_input_conditioner.md
Name: slc3_input_conditioner

Overview:
Receiving end of the SLC-3 front-panel inputs. It takes the raw active-low Run and Continue pushbuttons and the SW switch bus, and gives the CPU core clean, synchronized signals:
- a debounced pressed level for each button,
- a single-cycle press pulse for each button,
- a synchronized switch bus.

It sits between the top-level pins and slc3 control/datapath logic. It replaces direct use of the raw key inputs.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized cycles needed before a button state change is accepted. Must be >=1. Top level overrides it for hardware (e.g. 250000).
- SW_WIDTH, 10: width of the switch bus.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  raw Run key, active-low (0 = pressed), asynchronous to Clk.
- Continue  in  1  raw Continue key, active-low, asynchronous.
- SW  in  SW_WIDTH  raw switches, asynchronous.
- run_pressed  out  1  debounced Run level, active-high.
- run_pulse  out  1  one-cycle strobe on accepted Run press.
- continue_pressed  out  1  debounced Continue level, active-high.
- continue_pulse  out  1  one-cycle strobe on accepted Continue press.
- sw_sync  out  SW_WIDTH  two-flop synchronized SW.

Behaviour:
- Clocking and reset: one clock (Clk). Reset is synchronous and active-high. All state updates on the rising edge of Clk.

Each button channel (Run and Continue are identical and independent):
- Synchronizer: two flops, s1 <= raw, s2 <= s1. Reset value is 1 (released).
- stable register:
  - Active-low internal state; reset value 1.
  - pressed output = ~stable; reset 0.
- cnt: counter of width $clog2(DEBOUNCE_CYCLES)+1, reset value 0.
- Each edge, when not in reset:
  - If s2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
- pulse:
  - Registered; reset 0.
  - pulse <= 1 exactly on the edge where stable goes 1->0 (press accepted). Otherwise pulse <= 0.
  - Release acceptance produces no pulse.

Latency:
- Raw edge sampled at edge k gives s2 changed after edge k+1.
- pressed and pulse go high after edge k+1+DEBOUNCE_CYCLES.
- pulse is high for exactly one cycle.

Boundary conditions:
- Glitch shorter than DEBOUNCE_CYCLES synchronized cycles: cnt clears when s2 returns to stable. No output change.
- Bounce during counting restarts the count from 0.
- DEBOUNCE_CYCLES=1: change accepted on the first differing cycle (latency k+2).
- Key held through Reset: after reset deasserts, the key debounces as a new press and one pulse is produced.
- Reset mid-count: count is abandoned, outputs return to released/0 on that edge.
- Simultaneous Run and Continue presses: handled independently. Both pulses may assert in the same cycle.
- Counter never exceeds DEBOUNCE_CYCLES-1.

SW path:
- Two-flop synchronizer, no debounce. sw_sync reset value 0. Latency: 2 edges.

Decomposition:
- Package slc3_input_pkg:
  - SW_WIDTH default constant.
  - KEY_RELEASED = 1'b1 (raw level).
  - sync_stages constant = 2.
- Sub-module debounce_channel, parameter DEBOUNCE_CYCLES:
  - Ports: Clk, Reset, key_n, pressed, pulse.
  - Instantiated twice (Run, Continue).
- SW synchronizer is inline in the top.

Test Plan:
1. Reset: Reset=1 for 3 cycles with Run=Continue=1, SW=10'h3FF -> run/continue_pressed=0, pulses=0, sw_sync=0 during reset. sw_sync=10'h3FF two edges after reset drops.
2. Clean press: DEBOUNCE_CYCLES=4, Run driven 0 before edge k and held 20 cycles -> run_pressed=1 and run_pulse=1 after edge k+5. run_pulse=0 after edge k+6. Release gives run_pressed=0 after 5 more edges, no pulse.
3. Glitch rejection: DEBOUNCE_CYCLES=4, Continue low for 3 cycles then high -> continue_pressed and continue_pulse stay 0 throughout.
4. Bounce: Run pattern 0,0,1,0,0,0,0,0 (one per cycle) -> counter restarts at the 1. Exactly one run_pulse, 4 synchronized-stable cycles after the last bounce.
5. Simultaneous press and reset: both keys low together -> both pulses high in the same cycle. Then Reset asserted mid-count on a second press -> outputs 0 on the reset edge. Key still held after reset -> one new pulse after the 1+DEBOUNCE_CYCLES edge latency.
6. Long hold: Run held low 100 cycles -> exactly one run_pulse, run_pressed continuously 1 after acceptance.
